// File: rtl/aesl_deadlock_watchdog_if.sv
// Handshake bundle between the deadlock watchdog and its host.
// The host drives the arming, monitor and clear inputs; the watchdog returns its status.
interface aesl_deadlock_watchdog_if #(
   parameter int N_MON = 4,
   parameter int CNT_W = 16
);
   logic             enable;
   logic [N_MON-1:0] mon_block;
   logic             inst_idle;
   logic             clear;
   logic             deadlock;
   logic [N_MON-1:0] deadlock_mask;
   logic [4:0]       first_idx;
   logic [CNT_W-1:0] stall_cnt;
   logic [7:0]       event_cnt;
   logic [1:0]       state;

   modport master (
      output enable, mon_block, inst_idle, clear,
      input  deadlock, deadlock_mask, first_idx, stall_cnt, event_cnt, state
   );

   modport slave (
      input  enable, mon_block, inst_idle, clear,
      output deadlock, deadlock_mask, first_idx, stall_cnt, event_cnt, state
   );
endinterface

// File: rtl/aesl_deadlock_watchdog.sv
// Deadlock watchdog: declares a sticky deadlock after THRESH consecutive cycles of
// aggregate monitor blocking while the instance is not idle, and holds it until cleared.
module aesl_deadlock_watchdog #(
   parameter int N_MON  = 4,
   parameter int THRESH = 1024,
   parameter int CNT_W  = 16
) (
   input logic                   clock,
   input logic                   reset,
   aesl_deadlock_watchdog_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_SUSPECT  = 2'd2,
      ST_DEADLOCK = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] THRESH_M1_C = CNT_W'(THRESH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [N_MON-1:0] mask_q, mask_d;
   logic [7:0]       event_q, event_d;
   logic             blocked;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Lowest set bit wins; scanning downward lets the last hit be the lowest index.
   function automatic logic [4:0] lowest_idx(input logic [N_MON-1:0] v);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = N_MON - 1; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

   // Only the aggregate matters, so a changing bit pattern never breaks a stall run.
   assign blocked = (|bus.mon_block) & ~bus.inst_idle;

   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      mask_d  = mask_q;
      event_d = event_q;
      case (state_q)
         ST_IDLE: begin
            stall_d = '0;
            if (bus.enable) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
            end else if (blocked) begin
               state_d = ST_SUSPECT;
               stall_d = CNT_W'(1);
            end
         end
         ST_SUSPECT: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
               stall_d = '0;
            end else if (!blocked) begin
               state_d = ST_ARMED;
               stall_d = '0;
            end else if (stall_q == THRESH_M1_C) begin
               state_d = ST_DEADLOCK;
               stall_d = THRESH_C;
               mask_d  = bus.mon_block;
               event_d = sat_inc8(event_q);
            end else begin
               stall_d = stall_q + CNT_W'(1);
            end
         end
         ST_DEADLOCK: begin
            // Everything is frozen for post-mortem inspection until acknowledged.
            if (bus.clear) begin
               state_d = ST_IDLE;
               stall_d = '0;
               mask_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            stall_d = '0;
         end
      endcase
   end

   // Register stage
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         stall_q <= '0;
         mask_q  <= '0;
         event_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         mask_q  <= mask_d;
         event_q <= event_d;
      end
   end

   assign bus.state         = state_q;
   assign bus.deadlock      = (state_q == ST_DEADLOCK);
   assign bus.deadlock_mask = mask_q;
   assign bus.first_idx     = lowest_idx(mask_q);
   assign bus.stall_cnt     = stall_q;
   assign bus.event_cnt     = event_q;

endmodule

// File: doc/aesl_deadlock_watchdog.md
AESL_DEADLOCK_WATCHDOG -- requirements
Module: aesl_deadlock_watchdog

Interface
REQ-001 The block SHALL have parameter N_MON, default 4, giving the number of per-instance deadlock monitor inputs (range 1..32).
REQ-002 The block SHALL have parameter THRESH, default 1024, giving the consecutive blocked cycles that declare deadlock (range 2..65535).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the stall counter width; it must satisfy 2^CNT_W > THRESH.
REQ-004 clock  in  1  single clock domain; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  arms the watchdog; level-sensitive.
REQ-007 mon_block  in  N_MON  per-monitor block flags, one bit per sub-monitor.
REQ-008 inst_idle  in  1  design-under-test fully idle; blocking while idle is not a deadlock.
REQ-009 clear  in  1  single-cycle pulse that acknowledges and clears a reported deadlock.
REQ-010 deadlock  out  1  registered sticky deadlock flag.
REQ-011 deadlock_mask  out  N_MON  mon_block snapshot captured on deadlock declaration.
REQ-012 first_idx  out  5  index of the lowest set bit of deadlock_mask; 0 when the mask is zero.
REQ-013 stall_cnt  out  CNT_W  current consecutive-blocked count.
REQ-014 event_cnt  out  8  number of deadlocks declared since reset; saturating.
REQ-015 state  out  2  FSM encoding: IDLE=0, ARMED=1, SUSPECT=2, DEADLOCK=3.

Function
REQ-016 Blocked condition b SHALL be: (|mon_block) & ~inst_idle, sampled each rising edge.
REQ-017 IDLE: stall_cnt held at 0; if enable=1, next state is ARMED.
REQ-018 ARMED: if enable=0, next state is IDLE; else if b=1, next state is SUSPECT and stall_cnt becomes 1; else stay.
REQ-019 SUSPECT with enable=0: next state is IDLE and stall_cnt becomes 0.
REQ-020 SUSPECT with b=0: next state is ARMED and stall_cnt becomes 0; partial counts are never retained.
REQ-021 SUSPECT with b=1 and stall_cnt+1 < THRESH: stall_cnt increments and the state is held.
REQ-022 SUSPECT with b=1 and stall_cnt+1 == THRESH: next state is DEADLOCK, stall_cnt becomes THRESH, deadlock_mask captures mon_block, and event_cnt increments unless it is already 255.
REQ-023 Latency: deadlock SHALL read 1 on the cycle after the THRESH-th consecutive edge sampling b=1.
REQ-024 deadlock SHALL equal 1 exactly while state is DEADLOCK.
REQ-025 DEADLOCK: state, deadlock_mask and stall_cnt are held regardless of enable, mon_block or inst_idle.
REQ-026 DEADLOCK with clear=1: next state is IDLE, stall_cnt becomes 0 and deadlock_mask becomes 0; event_cnt is kept.
REQ-027 clear outside DEADLOCK SHALL have no effect.
REQ-028 first_idx SHALL be combinational from the registered deadlock_mask (priority encoder, lowest index wins).
REQ-029 A mon_block change during SUSPECT that keeps |mon_block=1 SHALL NOT reset the count; only the aggregate matters.

Reset
REQ-030 On reset=1 the block SHALL set: state=IDLE, deadlock=0, deadlock_mask=0, stall_cnt=0, event_cnt=0, first_idx=0.
REQ-031 reset SHALL override all other inputs in the same cycle, including mid-SUSPECT and in DEADLOCK.

Verification
REQ-032 THRESH=4, enable=1, mon_block=4'b0100 held -> ARMED, then SUSPECT with stall_cnt=1,2,3, then deadlock=1 on the cycle after the 4th blocked edge; mask=0100, first_idx=2, event_cnt=1.
REQ-033 THRESH=4, block held 3 cycles, then mon_block=0 for 1 cycle, then held again -> state returns to ARMED and stall_cnt=0; deadlock is reached only after 4 further consecutive blocked cycles.
REQ-034 mon_block=4'b0011 held with inst_idle=1 -> state stays ARMED, stall_cnt=0, deadlock=0 indefinitely.
REQ-035 In DEADLOCK, drop enable and mon_block, then pulse clear -> deadlock stays 1 until clear, then state=IDLE, mask=0, event_cnt unchanged.
REQ-036 reset asserted while in SUSPECT with stall_cnt=3 -> all outputs return to reset values on the next cycle.
REQ-037 Force 256 deadlock/clear cycles -> event_cnt saturates at 255.
